// File: rtl/freelist_allocator_pkg.sv
// Shared types and sizing for the physical-register free list.
package freelist_allocator_pkg;

  localparam int unsigned N         = 3;
  localparam int unsigned PHYS_REGS = 64;
  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned TagW      = $clog2(PHYS_REGS);
  localparam int unsigned CntW      = $clog2(PHYS_REGS + 1);
  localparam int unsigned RankW     = $clog2(N + 1);

  typedef logic [TagW-1:0]      phys_tag_t;
  typedef logic [PHYS_REGS-1:0] freelist_map_t;
  typedef logic [CntW-1:0]      free_cnt_t;

  // Tags 0..ARCH_REGS-1 hold the architectural state out of reset.
  localparam freelist_map_t ArchResetMap =
    {{(PHYS_REGS - ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};

  function automatic free_cnt_t popcount(freelist_map_t m);
    free_cnt_t cnt;
    cnt = '0;
    for (int i = 0; i < PHYS_REGS; i++) begin
      cnt = cnt + free_cnt_t'(m[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/freelist_allocator_pick_n.sv
// Finds the N lowest set bits of a bitmap, returned as one-hot vectors with valid flags.
module freelist_allocator_pick_n
  import freelist_allocator_pkg::*;
(
  input  freelist_map_t                      map_i,
  output logic [N-1:0][PHYS_REGS-1:0]        onehot_o,
  output logic [N-1:0]                       valid_o
);

  always_comb begin
    freelist_map_t rem;
    rem      = map_i;
    onehot_o = '0;
    valid_o  = '0;
    for (int k = 0; k < N; k++) begin
      // Two's-complement trick isolates the lowest set bit.
      onehot_o[k] = rem & (~rem + freelist_map_t'(1));
      valid_o[k]  = |rem;
      rem         = rem & ~onehot_o[k];
    end
  end

endmodule

// File: rtl/freelist_allocator.sv
// R10K physical-register free list with N-lane compacted grants and mispredict rebuild.
// Optional FREELIST_DOUBLE_FREE_CHECK_EN adds a sticky dbl_free_err_o flag.
module freelist_allocator
  import freelist_allocator_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N-1:0]                  alloc_req_i,
  output logic [N-1:0][PHYS_REGS-1:0]   granted_regs_o,
  output logic [N-1:0]                  grant_valid_o,
  output logic [CntW-1:0]               free_slots_o,
  input  logic [N-1:0]                  retire_valid_i,
  input  logic [N-1:0][TagW-1:0]        retire_phys_i,
  input  logic [N-1:0][TagW-1:0]        retire_told_i,
  input  logic                          recover_i
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
  ,
  output logic                          dbl_free_err_o
`endif
);

  freelist_map_t free_map_q, free_map_d;
  freelist_map_t arch_busy_q, arch_busy_d;
  free_cnt_t     free_cnt_q, free_cnt_d;

  freelist_map_t               pick_map;
  logic [N-1:0][PHYS_REGS-1:0] pick_onehot;
  logic [N-1:0]                pick_valid;

  // Tag 0 is reserved and must never reach the picker.
  assign pick_map = free_map_q & ~freelist_map_t'(1);

  freelist_allocator_pick_n u_pick (
    .map_i    (pick_map),
    .onehot_o (pick_onehot),
    .valid_o  (pick_valid)
  );

  always_comb begin
    logic [RankW-1:0] rank;
    rank           = '0;
    granted_regs_o = '0;
    grant_valid_o  = '0;
    for (int i = 0; i < N; i++) begin
      if (alloc_req_i[i]) begin
        if (pick_valid[rank] && !recover_i && rst_ni) begin
          grant_valid_o[i]  = 1'b1;
          granted_regs_o[i] = pick_onehot[rank];
        end
        rank = rank + RankW'(1);
      end
    end
  end

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
  logic dbl_free_q, dbl_free_d;
`endif

  always_comb begin
    freelist_map_t alloc_mask;
    freelist_map_t freed;
    alloc_mask  = '0;
    freed       = '0;
    arch_busy_d = arch_busy_q;
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    dbl_free_d  = dbl_free_q;
`endif
    for (int i = 0; i < N; i++) begin
      alloc_mask = alloc_mask | granted_regs_o[i];
      if (retire_valid_i[i]) begin
        arch_busy_d[retire_phys_i[i]] = 1'b1;
        if (retire_told_i[i] != '0) begin
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
          if (free_map_q[retire_told_i[i]] || freed[retire_told_i[i]]) begin
            dbl_free_d = 1'b1;
          end
`endif
          arch_busy_d[retire_told_i[i]] = 1'b0;
          freed[retire_told_i[i]]       = 1'b1;
        end
      end
    end
    if (recover_i) begin
      free_map_d = ~arch_busy_d;
    end else begin
      free_map_d = (free_map_q & ~alloc_mask) | freed;
    end
    free_map_d[0] = 1'b0;
    free_cnt_d    = popcount(free_map_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arch_busy_q <= ArchResetMap;
      free_map_q  <= ~ArchResetMap;
      free_cnt_q  <= free_cnt_t'(PHYS_REGS - ARCH_REGS);
    end else begin
      arch_busy_q <= arch_busy_d;
      free_map_q  <= free_map_d;
      free_cnt_q  <= free_cnt_d;
    end
  end

  assign free_slots_o = free_cnt_q;

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dbl_free_q <= 1'b0;
    end else begin
      dbl_free_q <= dbl_free_d;
    end
  end

  assign dbl_free_err_o = dbl_free_q;
`endif

endmodule

// File: tb/tb_freelist_allocator.sv
// Directed table-driven bench for freelist_allocator plus hand-written corner sequences.
module tb_freelist_allocator;

  logic                clk;
  logic                rst_n;
  logic [2:0]          alloc_req;
  logic [2:0][63:0]    granted_regs;
  logic [2:0]          grant_valid;
  logic [6:0]          free_slots;
  logic [2:0]          retire_valid;
  logic [2:0][5:0]     retire_phys;
  logic [2:0][5:0]     retire_told;
  logic                recover;
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
  logic                dbl_free_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  freelist_allocator dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .alloc_req_i    (alloc_req),
    .granted_regs_o (granted_regs),
    .grant_valid_o  (grant_valid),
    .free_slots_o   (free_slots),
    .retire_valid_i (retire_valid),
    .retire_phys_i  (retire_phys),
    .retire_told_i  (retire_told),
    .recover_i      (recover)
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    ,
    .dbl_free_err_o (dbl_free_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    logic [2:0]      alloc;
    logic [2:0]      rv;
    logic [2:0][5:0] phys;
    logic [2:0][5:0] told;
    logic            rec;
    logic [2:0]      gv;
    logic [2:0][5:0] tag;
    logic [6:0]      fs;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [2:0][5:0] t3(int l0, int l1, int l2);
    logic [2:0][5:0] r;
    r[0] = 6'(l0);
    r[1] = 6'(l1);
    r[2] = 6'(l2);
    return r;
  endfunction

  function automatic vec_t mk(logic rst, logic [2:0] alloc, logic [2:0] rv,
                              logic [2:0][5:0] phys, logic [2:0][5:0] told, logic rec,
                              logic [2:0] gv, logic [2:0][5:0] tag, int fs);
    vec_t v;
    v.rst = rst; v.alloc = alloc; v.rv = rv; v.phys = phys; v.told = told;
    v.rec = rec; v.gv = gv; v.tag = tag; v.fs = 7'(fs);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alloc_req    = '0;
    retire_valid = '0;
    retire_phys  = '0;
    retire_told  = '0;
    recover      = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    if (v.rst) reset_dut();
    alloc_req    = v.alloc;
    retire_valid = v.rv;
    retire_phys  = v.phys;
    retire_told  = v.told;
    recover      = v.rec;
    #1;
    chk("grant_valid", idx, 64'(grant_valid), 64'(v.gv));
    for (int l = 0; l < 3; l++) begin
      chk("granted_regs", idx * 10 + l, granted_regs[l],
          v.gv[l] ? (64'd1 << v.tag[l]) : 64'd0);
    end
    chk("free_slots", idx, 64'(free_slots), 64'(v.fs));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0][5:0] z;
    z     = t3(0, 0, 0);
    rst_n = 1'b0;
    idle_inputs();

    //          rst   alloc   rv      phys           told         rec   gv      tags             fs
    vecs.push_back(mk(1, 3'b111, 3'b000, z,            z,            0, 3'b111, t3(32, 33, 34), 32));
    vecs.push_back(mk(0, 3'b000, 3'b000, z,            z,            0, 3'b000, z,              29));
    vecs.push_back(mk(1, 3'b101, 3'b000, z,            z,            0, 3'b101, t3(32, 0, 33),  32));
    vecs.push_back(mk(0, 3'b000, 3'b000, z,            z,            0, 3'b000, z,              30));
    vecs.push_back(mk(1, 3'b001, 3'b001, t3(32, 0, 0), t3(5, 0, 0),  0, 3'b001, t3(32, 0, 0),   32));
    vecs.push_back(mk(0, 3'b001, 3'b000, z,            z,            0, 3'b001, t3(5, 0, 0),    32));
    vecs.push_back(mk(0, 3'b000, 3'b000, z,            z,            0, 3'b000, z,              31));
    vecs.push_back(mk(1, 3'b011, 3'b000, z,            z,            0, 3'b011, t3(32, 33, 0),  32));
    vecs.push_back(mk(0, 3'b110, 3'b000, z,            z,            0, 3'b110, t3(0, 34, 35),  30));
    // Lane0 frees tag 0 (ignored), lane2 frees p6; neither is grantable this cycle.
    vecs.push_back(mk(0, 3'b010, 3'b101, t3(40, 0, 41), t3(0, 0, 6), 0, 3'b010, t3(0, 36, 0),   28));
    vecs.push_back(mk(0, 3'b111, 3'b000, z,            z,            0, 3'b111, t3(6, 37, 38),  28));
    vecs.push_back(mk(0, 3'b000, 3'b000, z,            z,            0, 3'b000, z,              25));
    vecs.push_back(mk(1, 3'b111, 3'b000, z,            z,            0, 3'b111, t3(32, 33, 34), 32));
    vecs.push_back(mk(0, 3'b111, 3'b000, z,            z,            0, 3'b111, t3(35, 36, 37), 29));
    vecs.push_back(mk(0, 3'b000, 3'b010, t3(0, 32, 0), t3(0, 3, 0),  0, 3'b000, z,              26));
    vecs.push_back(mk(0, 3'b111, 3'b000, z,            z,            1, 3'b000, z,              27));
    vecs.push_back(mk(0, 3'b001, 3'b000, z,            z,            0, 3'b001, t3(3, 0, 0),    32));
    vecs.push_back(mk(0, 3'b000, 3'b000, z,            z,            0, 3'b000, z,              31));

    @(negedge clk);
    foreach (vecs[i]) apply(vecs[i], i);

    // Exhaustion: drain all 32 free tags, then starve, then refill one.
    reset_dut();
    for (int c = 0; c < 10; c++) begin
      alloc_req = 3'b111;
      #1;
      chk("drain_gv", c, 64'(grant_valid), 64'(3'b111));
      @(negedge clk);
    end
    alloc_req = 3'b111;
    #1;
    chk("partial_gv", 0, 64'(grant_valid), 64'(3'b011));
    chk("partial_lane1", 0, granted_regs[1], 64'd1 << 63);
    chk("partial_lane2", 0, granted_regs[2], 64'd0);
    @(negedge clk);
    alloc_req = 3'b111;
    #1;
    chk("empty_fs", 0, 64'(free_slots), 64'd0);
    chk("empty_gv", 0, 64'(grant_valid), 64'd0);
    @(negedge clk);
    idle_inputs();
    retire_valid = 3'b001;
    retire_phys  = t3(8, 0, 0);
    retire_told  = t3(7, 0, 0);
    #1;
    chk("empty_fs", 1, 64'(free_slots), 64'd0);
    @(negedge clk);
    idle_inputs();
    alloc_req = 3'b001;
    #1;
    chk("refill_fs", 0, 64'(free_slots), 64'd1);
    chk("refill_gv", 0, 64'(grant_valid), 64'(3'b001));
    chk("refill_lane0", 0, granted_regs[0], 64'd1 << 7);
    @(negedge clk);

    // Asynchronous reset in the middle of a cycle.
    reset_dut();
    alloc_req = 3'b111;
    @(negedge clk);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_fs", 0, 64'(free_slots), 64'd32);
    chk("async_rst_gv", 0, 64'(grant_valid), 64'd0);
    chk("async_rst_lane0", 0, granted_regs[0], 64'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    reset_dut();
    #1;
    chk("dbl_err_reset", 0, 64'(dbl_free_err), 64'd0);
    retire_valid = 3'b001;
    retire_phys  = t3(2, 0, 0);
    retire_told  = t3(40, 0, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("dbl_err_set", 0, 64'(dbl_free_err), 64'd1);
    for (int c = 0; c < 3; c++) @(negedge clk);
    chk("dbl_err_sticky", 0, 64'(dbl_free_err), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("dbl_err_clear", 0, 64'(dbl_free_err), 64'd0);
    chk("dbl_rst_fs", 0, 64'(free_slots), 64'd32);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
